// File: rtl/image_zoom_pkg.sv
// Shared types, opcodes and zoom helpers for the image zoom engine.
package image_zoom_pkg;

  localparam int LVL_W = 2;
  localparam int PAN_W = 8;

  localparam logic [3:0] OP_ZOOM_IN  = 4'd0;
  localparam logic [3:0] OP_ZOOM_OUT = 4'd1;
  localparam logic [3:0] OP_CLEAR    = 4'd2;
  localparam logic [3:0] OP_PAN_X    = 4'd3;
  localparam logic [3:0] OP_PAN_Y    = 4'd4;

  typedef logic [LVL_W-1:0]        lvl_t;
  typedef logic signed [PAN_W-1:0] pan_t;

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
    logic win;
  } tim_t;

  function automatic lvl_t sat_level(input logic [3:0] arg);
    return (arg > 4'd3) ? lvl_t'(3) : arg[LVL_W-1:0];
  endfunction

  // Centring offset for zoom-in level n: pixels*(2^n-1)/2, truncated.
  function automatic int zin_offset(input int pixels, input lvl_t n);
    return (pixels * ((1 << n) - 1)) / 2;
  endfunction

  function automatic int clamp_pix(input int v, input int max_v);
    if (v < 0)     return 0;
    if (v > max_v) return max_v;
    return v;
  endfunction

endpackage

// File: rtl/zoom_addr_map.sv
// Window-relative coordinates to frame-buffer address: zoom-in, zoom-out, clamp.
// Optional pan offsets are present only with IMAGE_ZOOM_PAN_EN defined.
module zoom_addr_map
  import image_zoom_pkg::*;
#(
  parameter int COL_PIXEL = 960,
  parameter int ROW_PIXEL = 540,
  parameter int ADDR_W    = 19,
  parameter int X_OFFSET  = 160,
  parameter int Y_OFFSET  = 90,
  parameter int CW        = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              win,
  input  logic [CW-1:0]     x_cnt,
  input  logic [CW-1:0]     y_cnt,
  input  lvl_t              zi,
  input  lvl_t              zo,
`ifdef IMAGE_ZOOM_PAN_EN
  input  pan_t              pan_x,
  input  pan_t              pan_y,
`endif
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr
);

  logic          win_q;
  logic [CW-1:0] col_q, row_q;
  lvl_t          zi_q, zo_q;
`ifdef IMAGE_ZOOM_PAN_EN
  pan_t          pan_x_q, pan_y_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
      zi_q  <= '0;
      zo_q  <= '0;
`ifdef IMAGE_ZOOM_PAN_EN
      pan_x_q <= '0;
      pan_y_q <= '0;
`endif
    end else begin
      win_q <= win;
      col_q <= win ? x_cnt - CW'(X_OFFSET) : '0;
      row_q <= win ? y_cnt - CW'(Y_OFFSET) : '0;
      zi_q  <= zi;
      zo_q  <= zo;
`ifdef IMAGE_ZOOM_PAN_EN
      pan_x_q <= pan_x;
      pan_y_q <= pan_y;
`endif
    end
  end

  int                zin_x, zin_y, zoom_x, zoom_y;
  logic [ADDR_W-1:0] addr_nxt;

  // NOTE: every variable here is fully assigned before any branch, so no
  // latch can be inferred.
  always_comb begin
    zin_x = (int'(col_q) + zin_offset(COL_PIXEL, zi_q)) >> zi_q;
    zin_y = (int'(row_q) + zin_offset(ROW_PIXEL, zi_q)) >> zi_q;
`ifdef IMAGE_ZOOM_PAN_EN
    zin_x = zin_x + int'(pan_x_q);
    zin_y = zin_y + int'(pan_y_q);
`endif
    zoom_x   = clamp_pix(zin_x << zo_q, COL_PIXEL - 1);
    zoom_y   = clamp_pix(zin_y << zo_q, ROW_PIXEL - 1);
    addr_nxt = ADDR_W'(zoom_y * COL_PIXEL + zoom_x);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en   <= win_q;
      rd_addr <= addr_nxt;
    end
  end

endmodule

// File: rtl/image_zoom_engine.sv
// Zoom engine top: command shadowing, frame lock, pixel counters, timing delay.
// Define IMAGE_ZOOM_PAN_EN to build the pan (opcodes 3/4) feature.
module image_zoom_engine
  import image_zoom_pkg::*;
#(
  parameter int COL_PIXEL  = 960,
  parameter int ROW_PIXEL  = 540,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 19,
  parameter int X_OFFSET   = 160,
  parameter int Y_OFFSET   = 90,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_data,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [DATA_W-1:0] data_out
);

  localparam int CW  = $clog2(COL_PIXEL > ROW_PIXEL ? COL_PIXEL : ROW_PIXEL) + 3;
  localparam int DLY = 2 + RD_LATENCY;

  logic          vs_q, de_q, locked, vs_rise;
  lvl_t          zi_sh, zo_sh, zi, zo;
  logic [CW-1:0] x_cnt, y_cnt;
  logic [3:0]    opcode, arg;
`ifdef IMAGE_ZOOM_PAN_EN
  pan_t          pan_x_sh, pan_y_sh, pan_x, pan_y;
`endif

  assign vs_rise = vs_in & ~vs_q;
  assign opcode  = cmd_data[7:4];
  assign arg     = cmd_data[3:0];

  // Active levels swap on the vs rise; a command in that cycle only reaches the shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zi_sh  <= '0;
      zo_sh  <= '0;
      zi     <= '0;
      zo     <= '0;
      locked <= 1'b0;
`ifdef IMAGE_ZOOM_PAN_EN
      pan_x_sh <= '0;
      pan_y_sh <= '0;
      pan_x    <= '0;
      pan_y    <= '0;
`endif
    end else begin
      if (vs_rise) begin
        zi     <= zi_sh;
        zo     <= zo_sh;
        locked <= 1'b1;
`ifdef IMAGE_ZOOM_PAN_EN
        pan_x  <= pan_x_sh;
        pan_y  <= pan_y_sh;
`endif
      end
      if (cmd_valid) begin
        case (opcode)
          OP_ZOOM_IN:  zi_sh <= sat_level(arg);
          OP_ZOOM_OUT: zo_sh <= sat_level(arg);
          OP_CLEAR: begin
            zi_sh <= '0;
            zo_sh <= '0;
`ifdef IMAGE_ZOOM_PAN_EN
            pan_x_sh <= '0;
            pan_y_sh <= '0;
`endif
          end
`ifdef IMAGE_ZOOM_PAN_EN
          OP_PAN_X: pan_x_sh <= {arg, 4'b0000};
          OP_PAN_Y: pan_y_sh <= {arg, 4'b0000};
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q  <= 1'b0;
      de_q  <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      vs_q  <= vs_in;
      de_q  <= de_in;
      x_cnt <= de_in ? x_cnt + 1'b1 : '0;
      if (vs_rise)
        y_cnt <= '0;
      else if (de_q && !de_in)
        y_cnt <= y_cnt + 1'b1;
    end
  end

  logic win;
  always_comb begin
    win = 1'b0;
    if (locked && de_in)
      win = (int'(x_cnt) >= X_OFFSET) && (int'(x_cnt) < X_OFFSET + (COL_PIXEL >> zo)) &&
            (int'(y_cnt) >= Y_OFFSET) && (int'(y_cnt) < Y_OFFSET + (ROW_PIXEL >> zo));
  end

  zoom_addr_map #(
    .COL_PIXEL (COL_PIXEL),
    .ROW_PIXEL (ROW_PIXEL),
    .ADDR_W    (ADDR_W),
    .X_OFFSET  (X_OFFSET),
    .Y_OFFSET  (Y_OFFSET),
    .CW        (CW)
  ) u_addr_map (
    .clk     (clk),
    .rst     (rst),
    .win     (win),
    .x_cnt   (x_cnt),
    .y_cnt   (y_cnt),
    .zi      (zi),
    .zo      (zo),
`ifdef IMAGE_ZOOM_PAN_EN
    .pan_x   (pan_x),
    .pan_y   (pan_y),
`endif
    .rd_en   (rd_en),
    .rd_addr (rd_addr)
  );

  tim_t dly [DLY];

  // NOTE: the delay line is reset so a mid-frame reset discards the frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DLY; i++) dly[i] <= '0;
    end else begin
      dly[0] <= '{vs: vs_in, hs: hs_in, de: de_in & locked, win: win};
      for (int i = 1; i < DLY; i++) dly[i] <= dly[i-1];
    end
  end

  assign vs_out   = dly[DLY-1].vs;
  assign hs_out   = dly[DLY-1].hs;
  assign de_out   = dly[DLY-1].de;
  assign data_out = dly[DLY-1].win ? rd_data : '0;

endmodule
